// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch unit bus bundle: imem request/response, redirect and decode handshake
interface inst_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - credit-limited instruction fetch with PC FIFO, instruction queue and redirect kill
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] kill_cnt_q, kill_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d;
  logic [PW-1:0] iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;

  logic [31:0] pf_mem_q  [DEPTH];
  logic [31:0] iq_inst_q [DEPTH];
  logic [31:0] iq_pc_q   [DEPTH];

  logic accept, rsp, discard, push, pop, credit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // Counts are registered, so a pop this cycle frees its slot only next cycle.
  assign credit  = (outstanding_q + count_q) < DEPTH_C;
  assign accept  = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp     = bus.imem_rsp_valid;
  assign discard = bus.redirect_valid || (state_q == DRAIN);
  assign push    = rsp && !discard;
  assign pop     = bus.id_valid && bus.id_ready;

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && credit;
  assign bus.imem_req_addr  = fetch_pc_q & 32'hFFFF_FFFC;
  assign bus.id_valid       = (count_q != '0);
  assign bus.id_inst        = bus.id_valid ? iq_inst_q[iq_rd_q] : 32'h0;
  assign bus.id_pc          = bus.id_valid ? iq_pc_q[iq_rd_q]   : 32'h0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(rsp);
    kill_cnt_d    = kill_cnt_q;
    count_d       = count_q;
    pf_wr_d       = accept ? ptr_inc(pf_wr_q) : pf_wr_q;
    pf_rd_d       = rsp ? ptr_inc(pf_rd_q) : pf_rd_q;
    iq_wr_d       = iq_wr_q;
    iq_rd_d       = iq_rd_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
      // Everything still in flight belongs to the wrong path, minus any response landing now.
      kill_cnt_d = outstanding_q - CW'(rsp);
      count_d    = '0;
      iq_wr_d    = '0;
      iq_rd_d    = '0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp && (kill_cnt_q != '0)) kill_cnt_d = kill_cnt_q - CW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) iq_wr_d = ptr_inc(iq_wr_q);
      if (pop)  iq_rd_d = ptr_inc(iq_rd_q);
    end

    state_d = (kill_cnt_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      kill_cnt_q    <= '0;
      count_q       <= '0;
      pf_wr_q       <= '0;
      pf_rd_q       <= '0;
      iq_wr_q       <= '0;
      iq_rd_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      kill_cnt_q    <= kill_cnt_d;
      count_q       <= count_d;
      pf_wr_q       <= pf_wr_d;
      pf_rd_q       <= pf_rd_d;
      iq_wr_q       <= iq_wr_d;
      iq_rd_q       <= iq_rd_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (accept) pf_mem_q[pf_wr_q] <= bus.imem_req_addr;
    if (push) begin
      iq_inst_q[iq_wr_q] <= bus.imem_rsp_data;
      iq_pc_q[iq_wr_q]   <= pf_mem_q[pf_rd_q];
    end
  end
endmodule
